rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- Round-robin arbiter and sequencer for NUM_REQ pipeline requesters sharing one single-port resource, such as the shared memory or writeback port.
- Grants one requester at a time and locks the grant for a multi-beat burst. The lock ends on the requester's last beat, on a burst-length cap, or when the owner abandons its request.
- The global stall freezes all state, consistent with the no-buffer global-stall pipeline.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- MAX_BURST, 8, maximum beats per grant before forced release (>=1).
- ID_W, $clog2(NUM_REQ), derived width of grant_id; not overridden.
- CNT_W, $clog2(MAX_BURST+1), derived width of beat_cnt; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  global stall; 1 freezes all state.
- req  input  NUM_REQ  per-requester request, held high for the whole burst.
- req_last  input  NUM_REQ  per-requester flag marking the current beat as final.
- res_ready  input  1  resource accepts a beat this cycle.
- grant  output  NUM_REQ  registered one-hot grant; all zero when idle.
- grant_id  output  ID_W  index of the owner; valid only when grant_valid=1.
- grant_valid  output  1  a grant is active.
- beat_cnt  output  CNT_W  beats completed in the current grant.
- forced_release  output  1  one-cycle pulse when a grant ends by the MAX_BURST cap.

Behaviour:
- **Reset** (reset_n=0, asynchronous)
  - grant=0, grant_id=0, grant_valid=0, beat_cnt=0, forced_release=0.
  - State=IDLE; priority pointer last_owner=NUM_REQ-1, so requester 0 has top priority first.
- **Beat definition**
  - fire = grant_valid & req[grant_id] & res_ready & ~stall.
- **Stall**
  - stall=1: no state, pointer, counter or output changes; no arbitration; forced_release=0 next cycle.
  - Stall has priority over every event below.
- **Arbitration (combinational select, registered result)**
  - Search req starting at index last_owner+1, modulo NUM_REQ; the first set bit wins.
  - The previous owner therefore has lowest priority.
- **FSM**
  - IDLE:
    - If |req and ~stall: load grant/grant_id with the winner, grant_valid=1, beat_cnt=0, go to GRANT.
    - Latency: request seen at cycle N gives grant at cycle N+1.
  - GRANT, on fire: beat_cnt+1, then check release conditions:
    - req_last[grant_id]=1: normal release.
    - Else beat_cnt+1 == MAX_BURST: forced release; forced_release=1 next cycle.
    - req_last on the MAX_BURST-th beat counts as a normal release, with no forced_release pulse.
  - GRANT, owner abandon: if req[grant_id]=0 and ~stall, release with no beat counted.
  - GRANT, otherwise (res_ready=0): hold the grant and beat_cnt.
- **Release**
  - last_owner <= grant_id.
  - Arbitrate the same cycle using current req, with the pointer advanced past the old owner.
  - If a winner exists: new grant next cycle, beat_cnt=0, stay in GRANT. This gives back-to-back grants with no bubble.
  - If no request: go to IDLE with grant=0, grant_valid=0, beat_cnt=0.
  - If the old owner is the only requester, it is re-granted (new burst, beat_cnt=0).
- **Invariants**
  - grant is always one-hot or zero, and grant_valid == |grant.
  - beat_cnt never exceeds MAX_BURST-1 while held.
- **Inputs**
  - Requests from non-owners while in GRANT are ignored until release.
  - req_last is ignored when not firing or not the owner.
- **Reset mid-burst**
  - Immediate return to the reset values; any partial burst is dropped without notification.

Test Plan:
- Reset, then req=0101, req_last=0101, res_ready=1, stall=0 → grant sequence 0001,0100,0001,0100 on consecutive cycles; first grant one cycle after req; no idle bubbles.
- req=0010 only, req_last=0, res_ready=1 → 8 beats with beat_cnt 0..7; forced_release=1 on the cycle after the 8th beat; requester 1 re-granted with beat_cnt=0.
- Owner 2 mid-burst at beat_cnt=3; assert stall for 5 cycles with res_ready=1 → grant=0100 and beat_cnt=3 unchanged throughout; counting resumes at 4 after stall drops.
- req=1111, each requester does 2-beat bursts (req_last on the 2nd beat) → grant order 0,1,2,3,0; each grant lasts exactly 2 cycles with res_ready=1.
- Owner 0 drops req at beat_cnt=1 while req[3]=1 → next cycle grant=1000, beat_cnt=0, forced_release=0.
- Assert reset_n=0 asynchronously mid-burst (between clock edges) → outputs go to zero immediately; after release with req=0100, grant=0100 on the first arbitration.

Source files
------------

// File: rtl/rr_burst_arbiter_if.sv
// Bundle of requester-side and resource-side signals for rr_burst_arbiter.
//   master : requester/pipeline side; drives stall, req, req_last, res_ready
//            and observes the grant outputs.
//   slave  : the arbiter; observes the inputs and drives grant, grant_id,
//            grant_valid, beat_cnt and forced_release.
// NUM_REQ and MAX_BURST must match the arbiter instance that uses this bundle.
interface rr_burst_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic               stall;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_last;
  logic               res_ready;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic [CNT_W-1:0]   beat_cnt;
  logic               forced_release;

  modport master (
    output stall, req, req_last, res_ready,
    input  grant, grant_id, grant_valid, beat_cnt, forced_release
  );

  modport slave (
    input  stall, req, req_last, res_ready,
    output grant, grant_id, grant_valid, beat_cnt, forced_release
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter for NUM_REQ requesters sharing one single-port
// resource. A grant is locked for a multi-beat burst and ends on the owner's
// last beat, on the MAX_BURST cap, or when the owner drops its request.
// On release the next winner is granted in the same cycle (no idle bubble).
// The global stall freezes every register.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : rr_burst_arbiter_if.slave
//             in : stall, req[NUM_REQ], req_last[NUM_REQ], res_ready
//             out: grant[NUM_REQ] (one-hot or zero), grant_id, grant_valid,
//                  beat_cnt, forced_release (1-cycle pulse on cap release)
module rr_burst_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input logic              clk,
  input logic              reset_n,
  rr_burst_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state;
  logic [NUM_REQ-1:0] grant_r;
  logic [ID_W-1:0]    grant_id_r;
  logic               grant_valid_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic               forced_r;
  logic [ID_W-1:0]    last_owner;

  logic               owner_req;
  logic               fire;
  logic [CNT_W-1:0]   beat_next;
  logic               rel_last;
  logic               rel_cap;
  logic               rel_abandon;
  logic               rel_now;
  logic [ID_W-1:0]    arb_ptr;
  logic               win_found;
  logic [ID_W-1:0]    win_id;

  assign owner_req   = bus.req[grant_id_r];
  assign fire        = grant_valid_r & owner_req & bus.res_ready & ~bus.stall;
  assign beat_next   = beat_cnt_r + 1'b1;
  // req_last wins over the cap, so a last beat landing on the cap is a
  // normal release without a forced_release pulse.
  assign rel_last    = fire & bus.req_last[grant_id_r];
  assign rel_cap     = fire & ~bus.req_last[grant_id_r] & (beat_next == CNT_W'(MAX_BURST));
  assign rel_abandon = grant_valid_r & ~owner_req & ~bus.stall;
  assign rel_now     = rel_last | rel_cap | rel_abandon;

  // While a grant is held the pointer used for the release-cycle arbitration
  // is the current owner, i.e. the value last_owner is about to take.
  assign arb_ptr = (state == GRANT) ? grant_id_r : last_owner;

  // Rotating priority search starting just after arb_ptr; the pointer
  // position itself is visited last, so a sole requester is re-granted.
  always_comb begin
    logic [ID_W-1:0] cand;
    int              idx;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(arb_ptr) + i) % NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      grant_r       <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      beat_cnt_r    <= '0;
      forced_r      <= 1'b0;
      last_owner    <= ID_W'(NUM_REQ - 1);
    end else if (bus.stall) begin
      forced_r <= 1'b0;
    end else begin
      forced_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state         <= GRANT;
            grant_r       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            grant_id_r    <= win_id;
            grant_valid_r <= 1'b1;
            beat_cnt_r    <= '0;
          end
        end
        GRANT: begin
          if (rel_now) begin
            last_owner <= grant_id_r;
            forced_r   <= rel_cap;
            beat_cnt_r <= '0;
            if (win_found) begin
              grant_r       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
              grant_id_r    <= win_id;
              grant_valid_r <= 1'b1;
            end else begin
              state         <= IDLE;
              grant_r       <= '0;
              grant_id_r    <= '0;
              grant_valid_r <= 1'b0;
            end
          end else if (fire) begin
            beat_cnt_r <= beat_next;
          end
        end
        default: begin
          state         <= IDLE;
          grant_r       <= '0;
          grant_id_r    <= '0;
          grant_valid_r <= 1'b0;
          beat_cnt_r    <= '0;
        end
      endcase
    end
  end

  assign bus.grant          = grant_r;
  assign bus.grant_id       = grant_id_r;
  assign bus.grant_valid    = grant_valid_r;
  assign bus.beat_cnt       = beat_cnt_r;
  assign bus.forced_release = forced_r;
endmodule
